// File: rtl/coax_buffered_rx.sv
// coax_rx: Manchester word receiver; rx line in, active/data/strobe/error out, rst active-high
module coax_rx #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       active,
  output logic [9:0] data,
  output logic       strobe,
  output logic       error
);
  localparam int H = CLOCKS_PER_BIT / 2;
  localparam int CW = $clog2(CLOCKS_PER_BIT) + 1;
  localparam int RW = $clog2(2 * CLOCKS_PER_BIT) + 1;
  localparam logic [CW-1:0] S1 = CW'(H / 2);
  localparam logic [CW-1:0] S2 = CW'(H + H / 2);
  localparam logic [CW-1:0] MID = CW'(H + 1);
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [RW-1:0] VMIN = RW'(5 * H / 2);
  localparam logic [RW-1:0] VMAX = RW'(7 * H / 2);
  localparam logic [RW-1:0] RONE = RW'(1);
  typedef enum logic {HUNT, RECV} state_t;
  state_t state_q;
  logic [1:0] sync_q;
  logic prv_q, hv_q, h1_q, active_q, strobe_q, error_q;
  logic [RW-1:0] rl_q;
  logic [CW-1:0] cnt_q;
  logic [3:0] pos_q;
  logic [9:0] sr_q, data_q;
  logic cur, edg, in_v;
  assign cur = sync_q[1];
  assign edg = cur ^ prv_q;
  assign in_v = rl_q >= VMIN && rl_q < VMAX;
  assign active = active_q;
  assign data = data_q;
  assign strobe = strobe_q;
  assign error = error_q;
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[0], rx};
    prv_q <= cur;
    rl_q <= edg ? RONE : (&rl_q ? rl_q : rl_q + RONE);
    strobe_q <= 1'b0;
    error_q <= 1'b0;
    if (rst) begin
      sync_q <= '0;
      prv_q <= 1'b0;
      rl_q <= '0;
      hv_q <= 1'b0;
      h1_q <= 1'b0;
      state_q <= HUNT;
      cnt_q <= '0;
      pos_q <= '0;
      sr_q <= '0;
      data_q <= '0;
      active_q <= 1'b0;
    end else if (state_q == HUNT) begin
      // start = a 1.5-bit high violation then a 1.5-bit low violation; the rising edge after it opens bit 0
      if (edg) hv_q <= !cur && in_v;
      if (edg && cur && hv_q && in_v) begin
        state_q <= RECV;
        active_q <= 1'b1;
        cnt_q <= ONE;
        pos_q <= '0;
      end
    end else begin
      cnt_q <= cnt_q == LAST ? '0 : cnt_q + ONE;
      // every bit has a mid-cell transition; lock the bit clock to it
      if (edg && cnt_q > S1 && cnt_q < S2) cnt_q <= MID;
      if (cnt_q == S1) h1_q <= cur;
      if (cnt_q == S2) begin
        if (cur == h1_q) begin
          error_q <= 1'b1;
          active_q <= 1'b0;
          hv_q <= 1'b0;
          state_q <= HUNT;
        end else if (pos_q == 4'd0) begin
          // sync bit: 1 = another word follows, 0 = end of frame
          pos_q <= h1_q ? 4'd1 : 4'd0;
          active_q <= h1_q;
          hv_q <= 1'b0;
          state_q <= h1_q ? RECV : HUNT;
        end else if (pos_q == 4'd11) begin
          pos_q <= '0;
          if (h1_q != ^sr_q) begin
            error_q <= 1'b1;
            active_q <= 1'b0;
            hv_q <= 1'b0;
            state_q <= HUNT;
          end else begin
            data_q <= sr_q;
            strobe_q <= 1'b1;
          end
        end else begin
          sr_q <= {sr_q[8:0], h1_q};
          pos_q <= pos_q + 4'd1;
        end
      end
    end
  end
endmodule

// fifo_sync_ram: first-word-fall-through FIFO; wr/wdata in, rd pops, rdata/empty/full out, rst active-high
module fifo_sync_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic wr_ok, rd_ok;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  // a write into a full FIFO is still taken when a pop frees the slot in the same cycle
  assign wr_ok = wr && (!full || rd);
  assign rd_ok = rd && !empty;
  assign rdata = mem_q[rp_q];
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wp_q] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(wr_ok);
      rp_q <= rp_q + AW'(rd_ok);
      cnt_q <= cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end
endmodule

// coax_buffered_rx: one coax frame into a FIFO; rx in, host pops data via read_strobe, empty/full/error/overflow/active out, reset active-low
module coax_buffered_rx #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       active,
  output logic [9:0] data,
  input  logic       read_strobe,
  output logic       empty,
  output logic       full,
  output logic       error,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, RECEIVING, ERROR} state_t;
  state_t state_q;
  logic error_q, overflow_q, flush_q;
  logic [9:0] rx_data;
  logic rx_strobe, rx_error;
  assign error = error_q;
  assign overflow = overflow_q;
  coax_rx #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_rx (
    .clk(clk), .rst(!reset), .rx(rx), .active(active),
    .data(rx_data), .strobe(rx_strobe), .error(rx_error)
  );
  // flush drops the previous frame's unread words as a new frame starts
  fifo_sync_ram #(.DEPTH(DEPTH), .WIDTH(10)) u_fifo (
    .clk(clk), .rst(!reset || flush_q), .wr(rx_strobe && state_q == RECEIVING),
    .wdata(rx_data), .rd(read_strobe), .rdata(data), .empty(empty), .full(full)
  );
  always_ff @(posedge clk) begin
    flush_q <= 1'b0;
    if (!reset) begin
      state_q <= IDLE;
      error_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (active) begin
          flush_q <= 1'b1;
          error_q <= 1'b0;
          overflow_q <= 1'b0;
          state_q <= RECEIVING;
        end
        RECEIVING: if (rx_error) begin
          error_q <= 1'b1;
          state_q <= ERROR;
        end else if (rx_strobe && full && !read_strobe) begin
          error_q <= 1'b1;
          overflow_q <= 1'b1;
          state_q <= ERROR;
        end else if (!active) state_q <= IDLE;
        ERROR: if (!active) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_coax_buffered_rx.sv
// tb_coax_buffered_rx: randomized frames against a queue-based model of the buffered receiver
module tb_coax_buffered_rx;
  localparam int CPB = 8;
  localparam int DEPTH = 4;
  localparam int H = CPB / 2;
  localparam int WORD_T = 12 * CPB;
  localparam int START_T = 6 * H;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b0;
  logic read_strobe = 1'b0;
  logic active, empty, full, error, overflow;
  logic [9:0] data;
  int checks = 0;
  int failures = 0;
  logic [9:0] fw[$];
  logic [9:0] exp_q[$];
  bit stream_en = 1'b0;

  coax_buffered_rx #(.CLOCKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx(rx), .active(active), .data(data),
    .read_strobe(read_strobe), .empty(empty), .full(full), .error(error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, want);
    end
  endtask

  task automatic hold(input logic v, input int halves);
    rx = v;
    repeat (halves * H) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    hold(b, 1);
    hold(!b, 1);
  endtask

  task automatic send_frame(input int bad);
    hold(1'b1, 3);
    hold(1'b0, 3);
    foreach (fw[i]) begin
      send_bit(1'b1);
      for (int j = 9; j >= 0; j--) send_bit(fw[i][j]);
      send_bit((^fw[i]) ^ (i == bad));
    end
    send_bit(1'b0);
    hold(1'b0, 4);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (stream_en && !empty) begin
        if (exp_q.size() == 0) chk("pop_extra", 1, 0);
        else chk("pop_data", data, exp_q.pop_front());
        read_strobe = 1'b1;
      end else read_strobe = 1'b0;
    end
  end

  task automatic drain_all();
    stream_en = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || !empty); i++) @(negedge clk);
    stream_en = 1'b0;
    @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
    chk("drain_empty", empty, 1);
  endtask

  // mode 0: no reads during the frame; 1: pop as soon as words land; 2: start popping after ~3 words
  task automatic run_frame(input int bad, input int mode, input bit drain);
    int g, keep;
    bit ov;
    g = bad >= 0 ? bad : fw.size();
    ov = mode == 0 && g > DEPTH;
    keep = ov ? DEPTH : g;
    if (mode != 0) drain_all();
    exp_q.delete();
    for (int i = 0; i < keep; i++) exp_q.push_back(fw[i]);
    stream_en = mode == 1;
    fork
      send_frame(bad);
      begin
        if (mode == 2) begin
          repeat (START_T + 3 * WORD_T + WORD_T / 2) @(negedge clk);
          stream_en = 1'b1;
        end
      end
    join
    chk("active_end", active, 0);
    chk("error", error, bad >= 0 || ov);
    chk("overflow", overflow, ov);
    if (mode == 0) begin
      chk("empty", empty, exp_q.size() == 0);
      chk("full", full, exp_q.size() == DEPTH);
    end
    if (drain || mode != 0) drain_all();
    stream_en = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_error", error, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_active", active, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    fw = '{10'h155, 10'h2AA, 10'h001};
    run_frame(-1, 0, 1'b1);
    fw = '{10'h011, 10'h022, 10'h033, 10'h044, 10'h055};
    run_frame(-1, 0, 1'b1);
    fw = '{10'h3C0, 10'h00F, 10'h2F1, 10'h1E2, 10'h0D3};
    run_frame(-1, 2, 1'b1);
    fw = '{10'h101, 10'h202, 10'h303, 10'h0F0};
    run_frame(1, 0, 1'b1);
    fw = '{10'h0AB, 10'h123};
    run_frame(-1, 0, 1'b0);
    fw = '{10'h3FF};
    run_frame(-1, 0, 1'b1);
    fw = '{10'h246, 10'h135, 10'h39C};
    fork
      send_frame(-1);
      begin
        repeat (START_T + 2 * WORD_T + 40) @(negedge clk);
        chk("pre_rst_empty", empty, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_empty", empty, 1);
        chk("midrst_error", error, 0);
        chk("midrst_active", active, 0);
        reset = 1'b1;
      end
    join
    exp_q.delete();
    chk("post_rst_empty", empty, 1);
    fw = '{10'h2C3, 10'h1D4};
    run_frame(-1, 0, 1'b1);
    for (int f = 0; f < 20; f++) begin
      int n, bad, mode;
      n = $urandom_range(1, 6);
      mode = $urandom_range(0, 2);
      bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      fw.delete();
      for (int i = 0; i < n; i++) fw.push_back(10'($urandom_range(0, 1023)));
      run_frame(bad, mode, 1'($urandom_range(0, 1)));
    end
    drain_all();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
